inst_queue: RTL

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_if.sv | 44 ++++
 rtl/inst_queue.sv | 105 ++++++++++
 2 files changed

// File: rtl/inst_queue_if.sv
// Fetch-to-issue instruction queue bundle: dual-slot push side, dual-entry head view, fill status.
// Optional ovf_cycles perf counter appears when IQ_PERF_CNT_EN is defined.
interface inst_queue_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          flush_que;
   logic [1:0]    push_valid;
   logic [31:0]   push_pc0;
   logic [31:0]   push_pc1;
   logic [31:0]   push_instr0;
   logic [31:0]   push_instr1;
   logic          stallI;
   logic [1:0]    issue_cnt;
   logic [1:0]    out_valid;
   logic [31:0]   out_pc0;
   logic [31:0]   out_pc1;
   logic [31:0]   out_instr0;
   logic [31:0]   out_instr1;
   logic          overflowI;
   logic [CW-1:0] count;
`ifdef IQ_PERF_CNT_EN
   logic [31:0]   ovf_cycles;
`endif

   modport master (
      output flush_que, push_valid, push_pc0, push_pc1, push_instr0, push_instr1,
      output stallI, issue_cnt,
      input  out_valid, out_pc0, out_pc1, out_instr0, out_instr1, overflowI, count
`ifdef IQ_PERF_CNT_EN
      , input ovf_cycles
`endif
   );

   modport slave (
      input  flush_que, push_valid, push_pc0, push_pc1, push_instr0, push_instr1,
      input  stallI, issue_cnt,
      output out_valid, out_pc0, out_pc1, out_instr0, out_instr1, overflowI, count
`ifdef IQ_PERF_CNT_EN
      , output ovf_cycles
`endif
   );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue: up to 2 pushes and 2 issues per cycle; optional IQ_PERF_CNT_EN overflow-cycle counter.
// Latency: a push is visible at the head outputs the cycle after it is written; no push-to-output bypass.
// Backpressure: overflowI warns upstream when free entries < OVF_MARGIN; pushes beyond free space are dropped.
module inst_queue #(
   parameter int DEPTH      = 8,
   parameter int OVF_MARGIN = 4
) (
   input logic       clk,
   input logic       reset,
   inst_queue_if.slave q
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   r_pc    [DEPTH];
   logic [31:0]   r_instr [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic [CW-1:0] w_free;
   logic [1:0]    w_req_n;
   logic [1:0]    w_push_n;
   logic [1:0]    w_issue;
   logic [1:0]    w_pop_n;
   logic [AW-1:0] w_head1;
   logic [AW-1:0] w_tail1;
   logic [31:0]   w_d0_pc;
   logic [31:0]   w_d0_instr;
   logic          w_ovf;

   assign w_free  = CW'(DEPTH) - r_count;
   assign w_head1 = r_head + AW'(1);
   assign w_tail1 = r_tail + AW'(1);
   assign w_ovf   = 32'(w_free) < 32'(OVF_MARGIN);

   // First accepted entry comes from slot1 only for the (illegal) 2'b10 pattern.
   assign w_d0_pc    = q.push_valid[0] ? q.push_pc0    : q.push_pc1;
   assign w_d0_instr = q.push_valid[0] ? q.push_instr0 : q.push_instr1;

   always_comb begin
      w_req_n = {1'b0, q.push_valid[0]} + {1'b0, q.push_valid[1]};
      if (w_free == '0)
         w_push_n = 2'd0;
      else if (w_free == CW'(1) && w_req_n == 2'd2)
         w_push_n = 2'd1;
      else
         w_push_n = w_req_n;

      w_issue = (q.issue_cnt == 2'd3) ? 2'd2 : q.issue_cnt;
      if (q.stallI)
         w_pop_n = 2'd0;
      else if (r_count < CW'(w_issue))
         w_pop_n = r_count[1:0];
      else
         w_pop_n = w_issue;
   end

   always_ff @(posedge clk) begin
      if (!reset && !q.flush_que) begin
         if (w_push_n != 2'd0) begin
            r_pc[r_tail]    <= w_d0_pc;
            r_instr[r_tail] <= w_d0_instr;
         end
         if (w_push_n == 2'd2) begin
            r_pc[w_tail1]    <= q.push_pc1;
            r_instr[w_tail1] <= q.push_instr1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || q.flush_que) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + AW'(w_pop_n);
         r_tail  <= r_tail + AW'(w_push_n);
         r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
      end
   end

   assign q.out_valid  = {r_count >= CW'(2), r_count >= CW'(1)};
   assign q.out_pc0    = r_pc[r_head];
   assign q.out_pc1    = r_pc[w_head1];
   assign q.out_instr0 = r_instr[r_head];
   assign q.out_instr1 = r_instr[w_head1];
   assign q.overflowI  = w_ovf;
   assign q.count      = r_count;

`ifdef IQ_PERF_CNT_EN
   logic [31:0] r_ovf_cycles;

   // Flush deliberately leaves this alone; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset)
         r_ovf_cycles <= '0;
      else if (w_ovf && r_ovf_cycles != 32'hFFFF_FFFF)
         r_ovf_cycles <= r_ovf_cycles + 32'd1;
   end

   assign q.ovf_cycles = r_ovf_cycles;
`endif
endmodule
